// File: rtl/ultrasonic_pkg.sv
// Shared definitions for the ultrasonic echo responder: register word indices, FSM state
// encoding, the no-object echo width default and the jitter LFSR constants.
`timescale 1ns/1ps
package ultrasonic_pkg;

  // Register word indices (PADDR[4:2])
  localparam logic [2:0] RegCtrl   = 3'd0;
  localparam logic [2:0] RegDelay  = 3'd1;
  localparam logic [2:0] RegEcho   = 3'd2;
  localparam logic [2:0] RegStatus = 3'd3;

  // STATUS[2:1] exposes the low two bits; HOLDOFF aliases IDLE there but busy tells them apart
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StTrig    = 3'd1,
    StArm     = 3'd2,
    StEcho    = 3'd3,
    StHoldoff = 3'd4
  } state_e;

  localparam int unsigned NoObjUsDefault = 38000;

  // Fibonacci LFSR, taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LfsrSeed = 16'hACE1;
  localparam logic [15:0] LfsrTaps = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LfsrTaps)};
  endfunction

endpackage

// File: rtl/us_tick_prescaler.sv
// Microsecond tick generator: counts 0..TICK_DIV-1 and pulses tick on the last count.
// restart forces the count back to 0 so a new timed phase starts on a clean boundary.
`timescale 1ns/1ps
module us_tick_prescaler #(
  parameter int unsigned TICK_DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q;

  assign tick = (cnt_q == CntMax);

  // Free-running divider, cleared on reset, restart or wrap
  always_ff @(posedge clk) begin
    if (rst || restart || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/ultrasonic_echo_responder.sv
// APB3 slave emulating the responder side of an HC-SR04-style trigger/echo ranger.
// Optional build macro ECHO_JITTER_EN adds 0..7 us of LFSR jitter to each echo width.
`timescale 1ns/1ps
module ultrasonic_echo_responder
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TICK_DIV    = 100,
  parameter int unsigned MIN_TRIG_US = 10,
  parameter int unsigned HOLDOFF_US  = 100,
  parameter int unsigned NO_OBJ_US   = NoObjUsDefault
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  input  logic        trigger,
  output logic        echo
);

  localparam logic [15:0] HoldoffCnt = 16'(HOLDOFF_US);
  localparam logic [16:0] MinTrigCnt = 17'(MIN_TRIG_US);
  localparam logic [15:0] NoObjCnt   = 16'(NO_OBJ_US);

  logic        trig_s1_q, trig_s2_q, trig_prev_q;
  logic        trig_rise, trig_fall;
  logic        en_q, no_obj_q;
  logic [15:0] delay_q, echo_us_q, trig_count_q;
  logic [31:0] prdata_q, rdata;
  logic        echo_q;
  state_e      state_q, state_d;
  logic [15:0] us_cnt_q, us_cnt_d, us_cnt_inc;
  logic [15:0] delay_lat_q, delay_lat_d, width_lat_q, width_lat_d;
  logic [15:0] width_base, width_sel;
  logic [16:0] trig_us;
  logic [2:0]  jitter_status;
  logic        accept, tick, restart;
  logic        apb_wr, apb_setup;
  logic [2:0]  reg_idx;
  logic        unused_ok;

  assign apb_wr    = PSEL & PENABLE & PWRITE;
  assign apb_setup = PSEL & ~PENABLE;
  assign reg_idx   = PADDR[4:2];
  assign unused_ok = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:16]};

  assign PRDATA  = prdata_q;
  assign PREADY  = 1'b1;
  assign PSLVERR = 1'b0;
  assign echo    = echo_q;

  assign trig_rise = trig_s2_q & ~trig_prev_q;
  assign trig_fall = ~trig_s2_q & trig_prev_q;

  assign width_base = no_obj_q ? NoObjCnt : echo_us_q;
  assign us_cnt_inc = (us_cnt_q == 16'hFFFF) ? us_cnt_q : us_cnt_q + 16'd1;
  // Include the tick landing on the fall cycle so a pulse of exactly N us measures N
  assign trig_us    = {1'b0, us_cnt_q} + {16'b0, tick};
  // Any state change realigns the prescaler so each phase is a whole number of ticks
  assign restart    = (state_d != state_q);

  us_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk     (PCLK),
    .rst     (PRESERN),
    .restart (restart),
    .tick    (tick)
  );

`ifdef ECHO_JITTER_EN
  logic [15:0] lfsr_q;
  logic [2:0]  jitter_q;
  logic [16:0] width_sum;

  assign width_sum     = {1'b0, width_base} + {14'b0, lfsr_q[2:0]};
  assign width_sel     = width_sum[16] ? 16'hFFFF : width_sum[15:0];
  assign jitter_status = jitter_q;

  // LFSR steps once per accepted trigger; the jitter used is kept for STATUS
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      lfsr_q   <= LfsrSeed;
      jitter_q <= 3'd0;
    end else if (accept) begin
      lfsr_q   <= lfsr_next(lfsr_q);
      jitter_q <= lfsr_q[2:0];
    end
  end
`else
  assign width_sel     = width_base;
  assign jitter_status = 3'd0;
`endif

  // Two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      trig_s1_q   <= 1'b0;
      trig_s2_q   <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_s1_q   <= trigger;
      trig_s2_q   <= trig_s1_q;
      trig_prev_q <= trig_s2_q;
    end
  end

  // FSM next-state and microsecond counter
  always_comb begin
    state_d     = state_q;
    us_cnt_d    = us_cnt_q;
    delay_lat_d = delay_lat_q;
    width_lat_d = width_lat_q;
    accept      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trig_rise && en_q) begin
          state_d  = StTrig;
          us_cnt_d = '0;
        end
      end
      StTrig: begin
        if (trig_fall) begin
          us_cnt_d = '0;
          if (trig_us >= MinTrigCnt) begin
            accept      = 1'b1;
            delay_lat_d = delay_q;
            width_lat_d = width_sel;
            state_d     = StArm;
          end else begin
            state_d = StIdle;
          end
        end else if (tick) begin
          us_cnt_d = us_cnt_inc;
        end
      end
      StArm: begin
        if (delay_lat_q == '0 || (tick && us_cnt_inc == delay_lat_q)) begin
          us_cnt_d = '0;
          state_d  = (width_lat_q == '0) ? StHoldoff : StEcho;
        end else if (tick) begin
          us_cnt_d = us_cnt_inc;
        end
      end
      StEcho: begin
        if (tick && us_cnt_inc == width_lat_q) begin
          us_cnt_d = '0;
          state_d  = StHoldoff;
        end else if (tick) begin
          us_cnt_d = us_cnt_inc;
        end
      end
      StHoldoff: begin
        if (tick && us_cnt_inc == HoldoffCnt) begin
          us_cnt_d = '0;
          state_d  = StIdle;
        end else if (tick) begin
          us_cnt_d = us_cnt_inc;
        end
      end
      default: state_d = StIdle;
    endcase
    // Disabling aborts whatever is in flight
    if (!en_q) begin
      state_d = StIdle;
      accept  = 1'b0;
    end
  end

  // FSM state, latched pulse parameters, registered echo and trigger counter
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      state_q      <= StIdle;
      us_cnt_q     <= '0;
      delay_lat_q  <= '0;
      width_lat_q  <= '0;
      echo_q       <= 1'b0;
      trig_count_q <= '0;
    end else begin
      state_q     <= state_d;
      us_cnt_q    <= us_cnt_d;
      delay_lat_q <= delay_lat_d;
      width_lat_q <= width_lat_d;
      echo_q      <= (state_d == StEcho);
      if (apb_wr && reg_idx == RegStatus) begin
        trig_count_q <= '0;
      end else if (accept && trig_count_q != 16'hFFFF) begin
        trig_count_q <= trig_count_q + 16'd1;
      end
    end
  end

  // APB register writes
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      en_q      <= 1'b0;
      no_obj_q  <= 1'b0;
      delay_q   <= '0;
      echo_us_q <= '0;
    end else if (apb_wr) begin
      case (reg_idx)
        RegCtrl: begin
          en_q     <= PWDATA[0];
          no_obj_q <= PWDATA[1];
        end
        RegDelay: delay_q   <= PWDATA[15:0];
        RegEcho:  echo_us_q <= PWDATA[15:0];
        default: ;
      endcase
    end
  end

  // Read mux
  always_comb begin
    rdata = '0;
    case (reg_idx)
      RegCtrl:   rdata = {30'b0, no_obj_q, en_q};
      RegDelay:  rdata = {16'b0, delay_q};
      RegEcho:   rdata = {16'b0, echo_us_q};
      RegStatus: rdata = {jitter_status, 5'b0, trig_count_q, 5'b0, state_q[1:0],
                          (state_q != StIdle)};
      default:   rdata = '0;
    endcase
  end

  // Read data captured in the setup phase, presented in the access phase
  always_ff @(posedge PCLK) begin
    if (PRESERN) begin
      prdata_q <= '0;
    end else if (apb_setup) begin
      prdata_q <= rdata;
    end
  end

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// Directed bench for ultrasonic_echo_responder with TICK_DIV=4, HOLDOFF_US=5.
// NO_OBJ_US is shortened to 300 so the no-object pulse stays short in simulation.
`timescale 1ns/1ps
module tb_ultrasonic_echo_responder;

  localparam int unsigned TickDiv = 4;

  logic        PCLK = 1'b0;
  logic        PRESERN;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic        trigger;
  logic        echo;

  int n_cmp = 0;
  int n_err = 0;

  ultrasonic_echo_responder #(
    .TICK_DIV    (TickDiv),
    .MIN_TRIG_US (10),
    .HOLDOFF_US  (5),
    .NO_OBJ_US   (300)
  ) dut (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR),
    .trigger (trigger),
    .echo    (echo)
  );

  always #5 PCLK = ~PCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    d = PRDATA;
    check_eq("pready", {31'b0, PREADY}, 32'd1);
    check_eq("pslverr", {31'b0, PSLVERR}, 32'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    apb_read(a, d);
    check_eq(tag, d, exp);
  endtask

  // Trigger held high for exactly us*TickDiv clock edges
  task automatic pulse_trigger(input int us);
    @(posedge PCLK); #1;
    trigger = 1'b1;
    repeat (us * TickDiv) @(posedge PCLK);
    #1;
    trigger = 1'b0;
  endtask

  // Edges from the trigger drop until echo is seen high; 0 on timeout
  task automatic wait_echo_rise(output int n);
    n = 0;
    do begin
      @(posedge PCLK); #1;
      n++;
    end while (!echo && n < 3000);
    if (!echo) n = 0;
  endtask

  task automatic measure_high(output int m);
    m = 0;
    while (echo && m < 5000) begin
      @(posedge PCLK); #1;
      m++;
    end
  endtask

  task automatic watch_quiet(input int cycles, output int highs);
    highs = 0;
    repeat (cycles) begin
      @(posedge PCLK); #1;
      if (echo) highs++;
    end
  endtask

  initial begin
    int n, m, highs;
    PRESERN = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; trigger = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    check_eq("rst_echo", {31'b0, echo}, 32'd0);
    check_eq("rst_prdata", PRDATA, 32'd0);
    PRESERN = 1'b0;
    read_check("rst_ctrl", 32'h00, 32'd0);
    read_check("rst_status", 32'h0C, 32'd0);

    // Register access
    apb_write(32'h04, 32'h0000_FFFF);
    read_check("delay_ffff", 32'h04, 32'h0000_FFFF);
    apb_write(32'h04, 32'hDEAD_BEEF);
    read_check("delay_mask", 32'h04, 32'h0000_BEEF);
    apb_write(32'h10, 32'hFFFF_FFFF);
    read_check("rd_0x10", 32'h10, 32'd0);

    // Normal ranging: 2 sync + 1 detect + 3us*4 = 15 edges, width 20us*4
    apb_write(32'h00, 32'd1);
    apb_write(32'h04, 32'd3);
    apb_write(32'h08, 32'd20);
    pulse_trigger(12);
    wait_echo_rise(n);
    check_eq("t1_latency", n, 32'd15);
    measure_high(m);
    check_eq("t1_width", m, 32'd80);
    repeat (40) @(posedge PCLK);
    read_check("t1_status", 32'h0C, 32'h0000_0100);

    // Short trigger rejected
    pulse_trigger(8);
    watch_quiet(60, highs);
    check_eq("t2_no_echo", highs, 32'd0);
    read_check("t2_status", 32'h0C, 32'h0000_0100);

    // Disabled: trigger ignored
    apb_write(32'h00, 32'd0);
    pulse_trigger(12);
    watch_quiet(60, highs);
    check_eq("t3_no_echo", highs, 32'd0);
    read_check("t3_status", 32'h0C, 32'h0000_0100);

    // No-object width (300us*4) with a retrigger during ECHO that must be ignored
    apb_write(32'h00, 32'd3);
    pulse_trigger(12);
    wait_echo_rise(n);
    check_eq("t4_latency", n, 32'd15);
    m = 0;
    while (echo && m < 5000) begin
      @(posedge PCLK); #1;
      m++;
      if (m == 100) trigger = 1'b1;
      if (m == 160) trigger = 1'b0;
    end
    check_eq("t4_width", m, 32'd1200);
    repeat (40) @(posedge PCLK);
    read_check("t4_status", 32'h0C, 32'h0000_0200);

    // Zero delay and width: no echo, HOLDOFF busy for 5us
    apb_write(32'h00, 32'd1);
    apb_write(32'h04, 32'd0);
    apb_write(32'h08, 32'd0);
    pulse_trigger(12);
    watch_quiet(8, highs);
    read_check("t5_busy", 32'h0C, 32'h0000_0301);
    watch_quiet(30, m);
    check_eq("t5_no_echo", highs + m, 32'd0);
    read_check("t5_idle", 32'h0C, 32'h0000_0300);

    // Any STATUS write clears trig_count
    apb_write(32'h0C, 32'd0);
    read_check("t6_clear", 32'h0C, 32'd0);

    // Disable mid-ECHO; DELAY=0 gives echo 4 edges after the drop
    apb_write(32'h08, 32'd20);
    pulse_trigger(12);
    wait_echo_rise(n);
    check_eq("t7_latency", n, 32'd4);
    repeat (10) @(posedge PCLK);
    apb_write(32'h00, 32'd0);
    check_eq("t7_echo_hold", {31'b0, echo}, 32'd1);
    @(posedge PCLK); #1;
    check_eq("t7_echo_off", {31'b0, echo}, 32'd0);
    read_check("t7_status", 32'h0C, 32'h0000_0100);

    // Reset mid-ECHO
    apb_write(32'h00, 32'd1);
    pulse_trigger(12);
    wait_echo_rise(n);
    check_eq("t8_latency", n, 32'd4);
    repeat (5) @(posedge PCLK);
    #1;
    PRESERN = 1'b1;
    @(posedge PCLK); #1;
    check_eq("t8_echo_rst", {31'b0, echo}, 32'd0);
    check_eq("t8_prdata_rst", PRDATA, 32'd0);
    @(posedge PCLK); #1;
    PRESERN = 1'b0;
    read_check("t8_ctrl", 32'h00, 32'd0);
    read_check("t8_delay", 32'h04, 32'd0);
    read_check("t8_echo_us", 32'h08, 32'd0);
    read_check("t8_status", 32'h0C, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ultrasonic_echo_responder.md
Name: ultrasonic_echo_responder

Overview:
- APB3 slave that emulates an HC-SR04-class ultrasonic ranger: the responder end of the trigger/echo protocol that DistanceSensor initiates.
- Watches the `trigger` input. After a qualifying pulse it waits a programmed delay, then drives `echo` high for a programmed width.
- Sits on a spare CoreAPB3 slot with FAB_CLK/M2F reset. Used for hardware-in-loop checks of the distance path without a physical sensor.

Parameters:
- TICK_DIV, 100, PCLK cycles per microsecond tick.
- MIN_TRIG_US, 10, minimum trigger high time (us) that counts as a valid trigger.
- HOLDOFF_US, 100, dead time (us) after echo falls before a new trigger is accepted.
- NO_OBJ_US, 38000, echo width (us) reported when no object is present.

Ports:
- PCLK  in  1  fabric clock (FAB_CLK).
- PRESERN  in  1  reset; synchronous, active-high (clock PCLK, reset PRESERN).
- PSEL  in  1  APB select.
- PENABLE  in  1  APB enable.
- PWRITE  in  1  APB write.
- PADDR  in  32  APB address; only [4:2] decoded.
- PWDATA  in  32  APB write data.
- PRDATA  out  32  APB read data.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  tied 0.
- trigger  in  1  asynchronous trigger from the initiator.
- echo  out  1  echo pulse to the initiator.

Behaviour:
- Registers (word offsets):
  - 0x00 CTRL: [0] EN, [1] NO_OBJ, RW.
  - 0x04 DELAY_US: [15:0], RW.
  - 0x08 ECHO_US: [15:0], RW.
  - 0x0C STATUS, RO: [0] busy (state not IDLE), [2:1] state, [23:8] trig_count (saturating at 0xFFFF). Any write to 0x0C clears trig_count.
  - Other offsets read 0; writes to them are ignored.
- APB timing: writes take effect on PSEL&PENABLE&PWRITE. PRDATA is registered on the setup phase (PSEL&!PENABLE) and valid in the access phase. Zero wait states.
- Reset: all registers 0, echo=0, PRDATA=0, FSM=IDLE, prescaler=0, trigger synchronizer=0.
- trigger passes through a 2-flop synchronizer; all edge detection uses the synchronized copy (2-cycle input latency).
- Tick: a prescaler counts 0..TICK_DIV-1 and pulses `tick` at TICK_DIV-1. It restarts at 0 on every FSM transition, so each timed phase lasts exactly N*TICK_DIV cycles.
- FSM:
  - IDLE: on a rising edge with EN=1, go to TRIG and clear the us counter.
  - TRIG: count ticks while trigger is high. On the falling edge:
    - count >= MIN_TRIG_US: latch DELAY_US and the width (NO_OBJ ? NO_OBJ_US : ECHO_US), increment trig_count, go to ARM.
    - otherwise: go to IDLE; not counted.
  - ARM: wait latched DELAY ticks, then go to ECHO. DELAY=0 enters ECHO on the next cycle.
  - ECHO: echo=1 (registered) for exactly width*TICK_DIV cycles, then go to HOLDOFF. width=0 skips ECHO entirely; echo never rises.
  - HOLDOFF: wait HOLDOFF_US ticks, then go to IDLE.
- Trigger edges in ARM, ECHO and HOLDOFF are ignored and not counted.
- Register writes during ARM/ECHO do not affect the pulse in flight; values are latched at the trigger fall.
- EN cleared in any non-IDLE state: next cycle echo=0 and FSM=IDLE.
- Reset asserted mid-pulse: echo=0 on the next PCLK edge.
- Counters are 16-bit, sized for NO_OBJ_US; the TRIG counter saturates at 0xFFFF.

Optional Feature:
- Macro ECHO_JITTER_EN.
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 at reset) advances once per accepted trigger, and LFSR[2:0] us is added to the latched echo width. STATUS[31:29] reports the jitter applied.
  - Undefined: echo width is exact; STATUS[31:29] reads 0.

Decomposition:
- Shared package ultrasonic_pkg holds: register offset constants, state enum (IDLE, TRIG, ARM, ECHO, HOLDOFF, encoded 2:0 with STATUS[2:1] = low bits), NO_OBJ_US default, LFSR seed/taps.
- One natural sub-module: us_tick_prescaler (inputs clk, rst, restart; output tick).

Test Plan (TICK_DIV=4, HOLDOFF_US=5):
- EN=1, DELAY=3, ECHO=20; trigger high 12 us -> echo rises 12 cycles after the synchronized fall, stays high 80 cycles; trig_count=1.
- Trigger high 8 us -> no echo; trig_count unchanged; FSM back to IDLE.
- NO_OBJ=1, ECHO=20 -> echo width 38000*4 cycles. Second trigger during ECHO -> ignored, trig_count +1 only.
- ECHO=0, DELAY=0, valid trigger -> echo stays 0; busy=1 for 5 us of HOLDOFF, then 0.
- Clear EN mid-ECHO -> echo=0 the cycle after the APB write completes, STATUS busy=0. Reset mid-ECHO -> echo=0 the next cycle, all registers 0.
- APB: write 0x04=0xFFFF, read back 0x0000FFFF. Read 0x10 -> 0. Write 0x0C -> trig_count=0. PREADY=1 and PSLVERR=0 throughout.
